bus_req_port: RTL and testbench

BUS_REQ_PORT -- requirements
Module: bus_req_port

---
 rtl/bus_req_if.sv | 26 ++
 rtl/bus_req_port.sv | 122 ++++++++++++
 tb/tb_bus_req_port.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/bus_req_if.sv
// bus_req_if -- request/grant/data bus between a requesting port and the
// queue arbiter plus the shared data bus.
//   master : requester side (bus_req_port) drives req/send/dest/bus_data/bus_en
//   slave  : arbiter side drives ack/grant_valid/grant_send
interface bus_req_if #(
    parameter int DW = 32
);
    logic          req;
    logic [3:0]    send;
    logic [3:0]    dest;
    logic          ack;
    logic          grant_valid;
    logic [3:0]    grant_send;
    logic [DW-1:0] bus_data;
    logic          bus_en;

    modport master (
        output req, send, dest, bus_data, bus_en,
        input  ack, grant_valid, grant_send
    );

    modport slave (
        input  req, send, dest, bus_data, bus_en,
        output ack, grant_valid, grant_send
    );
endinterface

// File: rtl/bus_req_port.sv
// bus_req_port -- queues up to two local transfers and moves each one onto
// the shared bus: request the arbiter, wait for a grant naming MY_ID, then
// drive BEATS data beats.
//   clk, clr      : clock, asynchronous active-high reset
//   tx_valid/tx_dest/tx_payload/tx_ready : local push handshake
//   bus           : request/grant/data bus (master modport)
//   busy          : queue non-empty or a transfer in progress
//   spurious_gnt  : sticky, a grant for MY_ID arrived outside WAIT_GNT
module bus_req_port #(
    parameter logic [3:0] MY_ID = 4'h0,
    parameter int         DW    = 32,
    parameter int         BEATS = 4
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                tx_valid,
    input  logic [3:0]          tx_dest,
    input  logic [DW*BEATS-1:0] tx_payload,
    output logic                tx_ready,
    bus_req_if.master           bus,
    output logic                busy,
    output logic                spurious_gnt
);
    localparam int PW = DW * BEATS;
    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_GNT, XFER} state_t;

    state_t        state, state_nxt;
    logic [3:0]    q_dest [2];
    logic [PW-1:0] q_pay  [2];
    logic          rd_ptr, wr_ptr;
    logic [1:0]    cnt, cnt_nxt;
    logic [BW-1:0] beat;
    logic          push, pop, last_beat, grant_me;
    logic          req_o, en_o;

    assign tx_ready  = (cnt != 2'd2);
    assign push      = tx_valid && tx_ready;
    assign last_beat = (state == XFER) && (beat == BW'(BEATS - 1));
    assign pop       = last_beat;
    assign grant_me  = bus.grant_valid && (bus.grant_send == MY_ID);

    always_comb begin
        cnt_nxt = cnt;
        case ({push, pop})
            2'b10:   cnt_nxt = cnt + 2'd1;
            2'b01:   cnt_nxt = cnt - 2'd1;
            default: cnt_nxt = cnt;
        endcase
    end

    // Queue bookkeeping; storage itself needs no reset since cnt gates it.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt    <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_dest[wr_ptr] <= tx_dest;
            q_pay[wr_ptr]  <= tx_payload;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (cnt != 2'd0) state_nxt = REQ;
            REQ:      if (bus.ack)     state_nxt = WAIT_GNT;
            WAIT_GNT: if (grant_me)    state_nxt = XFER;
            XFER:     if (last_beat)   state_nxt = (cnt_nxt != 2'd0) ? REQ : IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        req_o = 1'b0;
        en_o  = 1'b0;
        case (state)
            REQ:     req_o = 1'b1;
            XFER:    en_o  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr)                 beat <= '0;
        else if (state != XFER)  beat <= '0;
        else if (last_beat)      beat <= '0;
        else                     beat <= beat + 1'b1;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr)                              spurious_gnt <= 1'b0;
        else if (grant_me && state != WAIT_GNT) spurious_gnt <= 1'b1;
    end

    // Head entry is stable from REQ to the end of XFER since pop only
    // happens on the last beat.
    assign bus.req      = req_o;
    assign bus.bus_en   = en_o;
    assign bus.send     = MY_ID;
    assign bus.dest     = req_o ? q_dest[rd_ptr] : 4'h0;
    assign bus.bus_data = en_o ? q_pay[rd_ptr][beat*DW +: DW] : '0;
    assign busy         = (cnt != 2'd0) || (state != IDLE);
endmodule

// File: tb/tb_bus_req_port.sv
module tb_bus_req_port;
    localparam logic [3:0] MY_ID = 4'h5;
    localparam int DW = 8, BEATS = 4, PW = DW * BEATS;

    logic          clk = 1'b0;
    logic          clr;
    logic          tx_valid;
    logic [3:0]    tx_dest;
    logic [PW-1:0] tx_payload;
    logic          tx_ready, busy, spurious_gnt;

    bus_req_if #(.DW(DW)) bus();

    bus_req_port #(.MY_ID(MY_ID), .DW(DW), .BEATS(BEATS)) dut (
        .clk(clk), .clr(clr), .tx_valid(tx_valid), .tx_dest(tx_dest),
        .tx_payload(tx_payload), .tx_ready(tx_ready), .bus(bus),
        .busy(busy), .spurious_gnt(spurious_gnt)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;

    // reference model state for the random phase
    logic [3:0]    qd[$];
    logic [PW-1:0] qp[$];
    int            bidx = 0;
    bit            pend_push = 0, pend_pop = 0;
    logic [3:0]    pd;
    logic [PW-1:0] pp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        tx_valid = 1'b0; tx_dest = 4'h0; tx_payload = '0;
        bus.ack = 1'b0; bus.grant_valid = 1'b0; bus.grant_send = 4'h0;
    endtask

    task automatic push_one(input logic [3:0] d, input logic [PW-1:0] p);
        tx_valid = 1'b1; tx_dest = d; tx_payload = p;
        step();
        tx_valid = 1'b0;
    endtask

    // Expects the port in REQ now; acks, waits gdly cycles, grants, checks beats.
    task automatic serve(input string tag, input logic [3:0] d, input logic [PW-1:0] p, input int gdly);
        chk({tag, "_req"}, 64'(bus.req), 64'd1);
        chk({tag, "_dest"}, 64'(bus.dest), 64'(d));
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        chk({tag, "_req_drop"}, 64'(bus.req), 64'd0);
        for (int i = 0; i < gdly; i++) begin
            chk({tag, "_wait_noen"}, 64'(bus.bus_en), 64'd0);
            step();
        end
        bus.grant_valid = 1'b1; bus.grant_send = MY_ID;
        step();
        bus.grant_valid = 1'b0;
        for (int k = 0; k < BEATS; k++) begin
            chk({tag, "_en"}, 64'(bus.bus_en), 64'd1);
            chk({tag, "_data"}, 64'(bus.bus_data), 64'(p[k*DW +: DW]));
            step();
        end
    endtask

    task automatic rnd_cycle(input bit drain);
        logic [PW-1:0] hp;
        step();
        if (pend_pop)  begin void'(qd.pop_front()); void'(qp.pop_front()); pend_pop = 0; end
        if (pend_push) begin qd.push_back(pd); qp.push_back(pp); pend_push = 0; end
        chk("rnd_ready", 64'(tx_ready), 64'(qd.size() < 2));
        chk("rnd_busy", 64'(busy), 64'(qd.size() != 0));
        if (bus.req) begin
            chk("rnd_req_nonempty", 64'(qd.size() != 0), 64'd1);
            if (qd.size() != 0) chk("rnd_dest", 64'(bus.dest), 64'(qd[0]));
            chk("rnd_req_noen", 64'(bus.bus_en), 64'd0);
        end
        if (bus.bus_en) begin
            chk("rnd_en_nonempty", 64'(qd.size() != 0), 64'd1);
            if (qd.size() != 0) begin
                hp = qp[0];
                chk("rnd_data", 64'(bus.bus_data), 64'(hp[bidx*DW +: DW]));
            end
            bidx++;
            if (bidx == BEATS) begin pend_pop = 1; bidx = 0; end
        end else begin
            chk("rnd_burst_len", 64'(bidx), 64'd0);
            chk("rnd_data_zero", 64'(bus.bus_data), 64'd0);
        end
        tx_valid = drain ? 1'b0 : ($urandom_range(0, 2) == 0);
        pd = 4'($urandom); pp = PW'($urandom);
        tx_dest = pd; tx_payload = pp;
        pend_push = tx_valid && (qd.size() < 2);
        bus.ack = drain ? 1'b1 : 1'($urandom_range(0, 1));
        bus.grant_valid = drain ? 1'b1 : ($urandom_range(0, 3) == 0);
        bus.grant_send = (drain || $urandom_range(0, 1) == 1) ? MY_ID : (MY_ID + 4'($urandom_range(1, 15)));
    endtask

    initial begin
        int guard;
        clr = 1'b0;
        idle_in();
        #2 clr = 1'b1;
        #2;
        chk("rst_req", 64'(bus.req), 64'd0);
        chk("rst_en", 64'(bus.bus_en), 64'd0);
        chk("rst_data", 64'(bus.bus_data), 64'd0);
        chk("rst_dest", 64'(bus.dest), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_spur", 64'(spurious_gnt), 64'd0);
        chk("rst_ready", 64'(tx_ready), 64'd1);
        chk("rst_send", 64'(bus.send), 64'(MY_ID));
        step();
        clr = 1'b0;
        step();

        // single transfer, grant two cycles after ack
        push_one(4'h3, {8'hD, 8'hC, 8'hB, 8'hA});
        chk("single_idle_noreq", 64'(bus.req), 64'd0);
        chk("single_busy", 64'(busy), 64'd1);
        step();
        serve("single", 4'h3, {8'hD, 8'hC, 8'hB, 8'hA}, 2);
        chk("single_done_en", 64'(bus.bus_en), 64'd0);
        chk("single_done_busy", 64'(busy), 64'd0);

        // back-to-back transfers
        push_one(4'h1, 32'h11223344);
        push_one(4'h2, 32'h55667788);
        chk("b2b_full", 64'(tx_ready), 64'd0);
        serve("b2b_first", 4'h1, 32'h11223344, 0);
        chk("b2b_second_ready", 64'(tx_ready), 64'd1);
        serve("b2b_second", 4'h2, 32'h55667788, 1);
        chk("b2b_done_busy", 64'(busy), 64'd0);

        // ack stall, then foreign grant
        push_one(4'h9, 32'hCAFEF00D);
        step();
        for (int i = 0; i < 10; i++) begin
            chk("stall_req", 64'(bus.req), 64'd1);
            chk("stall_dest", 64'(bus.dest), 64'h9);
            chk("stall_noen", 64'(bus.bus_en), 64'd0);
            step();
        end
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        bus.grant_valid = 1'b1; bus.grant_send = MY_ID + 4'h1;
        step();
        bus.grant_valid = 1'b0;
        chk("foreign_noen", 64'(bus.bus_en), 64'd0);
        chk("foreign_noreq", 64'(bus.req), 64'd0);
        chk("foreign_nospur", 64'(spurious_gnt), 64'd0);
        step();
        chk("foreign_still_wait", 64'(bus.bus_en), 64'd0);
        bus.grant_valid = 1'b1; bus.grant_send = MY_ID;
        step();
        bus.grant_valid = 1'b0;
        for (int k = 0; k < BEATS; k++) begin
            chk("foreign_served_en", 64'(bus.bus_en), 64'd1);
            chk("foreign_served_data", 64'(bus.bus_data), 64'((32'hCAFEF00D >> (k*DW)) & 32'hFF));
            step();
        end
        chk("foreign_done_busy", 64'(busy), 64'd0);

        // spurious grant in IDLE, sticky
        bus.grant_valid = 1'b1; bus.grant_send = MY_ID;
        step();
        bus.grant_valid = 1'b0;
        chk("spur_set", 64'(spurious_gnt), 64'd1);
        chk("spur_noen", 64'(bus.bus_en), 64'd0);
        step(); step(); step();
        chk("spur_sticky", 64'(spurious_gnt), 64'd1);

        // reset during beat 1
        push_one(4'h7, 32'h01020304);
        step();
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        bus.grant_valid = 1'b1; bus.grant_send = MY_ID;
        step();
        bus.grant_valid = 1'b0;
        step();
        chk("rmid_beat1", 64'(bus.bus_data), 64'h03);
        clr = 1'b1;
        #1;
        chk("rmid_en", 64'(bus.bus_en), 64'd0);
        chk("rmid_req", 64'(bus.req), 64'd0);
        chk("rmid_data", 64'(bus.bus_data), 64'd0);
        chk("rmid_spur_clr", 64'(spurious_gnt), 64'd0);
        step();
        clr = 1'b0;
        step();
        chk("rmid_busy", 64'(busy), 64'd0);
        chk("rmid_ready", 64'(tx_ready), 64'd1);
        chk("rmid_noreq", 64'(bus.req), 64'd0);

        // randomized traffic against the queue model
        for (int c = 0; c < 1500; c++) rnd_cycle(1'b0);
        guard = 0;
        while ((qd.size() != 0 || pend_push || pend_pop) && guard < 200) begin
            rnd_cycle(1'b1);
            guard++;
        end
        chk("drain_empty", 64'(qd.size()), 64'd0);
        chk("drain_in_time", 64'(guard < 200), 64'd1);
        idle_in();
        step();
        chk("final_busy", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
